// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: locks onto an incoming VGA raster, checks sync timing and
// blanking, and produces a CRC-16-CCITT signature of every completed frame.
module vga_frame_monitor #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int RGB_W     = 6,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [RGB_W-1:0] rgb,
    input  logic             clear_err,
    output logic             locked,
    output logic             frame_done,
    output logic [15:0]      frame_crc,
    output logic [15:0]      frame_count,
    output logic             err_hsync,
    output logic             err_vsync,
    output logic             err_blank
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ALIGN = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t state, state_next;

    logic             hs_r, vs_r, hs_prev, vs_prev, vs_line;
    logic [RGB_W-1:0] rgb_r;
    logic [CNT_W-1:0] h_cnt, v_cnt, cur_h, cur_v;
    logic [15:0]      crc;
    logic             end_pend;
    logic             line_start, hs_fall, vs_edge, v_assert_line, v_deassert_line;
    logic             active, last_px, tracking, det_h, det_v, det_b, any_err;

    // Serial CRC-16-CCITT (poly 0x1021) over one pixel, MSB first, unrolled so a whole pixel folds in per cycle.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [RGB_W-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Register the pins once, storing syncs as "asserted" flags so polarity disappears from the rest of the logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r    <= 1'b0;
            vs_r    <= 1'b0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            rgb_r   <= '0;
        end else begin
            hs_r    <= (hsync == HSYNC_POL);
            vs_r    <= (vsync == VSYNC_POL);
            hs_prev <= hs_r;
            vs_prev <= vs_r;
            rgb_r   <= rgb;
        end
    end

    assign line_start      = hs_r & ~hs_prev;
    assign hs_fall         = ~hs_r & hs_prev;
    assign vs_edge         = vs_r & ~vs_prev;
    assign v_assert_line   = line_start & vs_r & ~vs_line;
    assign v_deassert_line = line_start & ~vs_r & vs_line;

    assign cur_h = line_start ? '0 : h_cnt + CNT_W'(1);
    assign cur_v = v_assert_line ? '0 : (line_start ? v_cnt + CNT_W'(1) : v_cnt);

    assign active  = (cur_h >= H_ACT_START) && (cur_h < H_ACT_END) &&
                     (cur_v >= V_ACT_START) && (cur_v < V_ACT_END);
    assign last_px = active && (cur_h == H_ACT_LAST) && (cur_v == V_ACT_LAST);

    assign tracking = en && (state == TRACK);

    assign det_h = tracking && ((line_start && (h_cnt != H_LAST)) ||
                                (!line_start && (h_cnt == H_LAST)) ||
                                (hs_fall && (cur_h != H_SYNC_END)));
    assign det_v = tracking && ((v_assert_line && (v_cnt != V_LAST)) ||
                                (v_deassert_line && (cur_v != V_SYNC_END)) ||
                                (line_start && !v_assert_line && (v_cnt == V_LAST)));
    assign det_b = tracking && !active && (rgb_r != '0);
    assign any_err = det_h | det_v | det_b;

    // Lock sequence: wait for a vsync edge, align on the following line start, then track until an error.
    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = SEEK;
        end else begin
            case (state)
                SEEK:    if (vs_edge) state_next = ALIGN;
                ALIGN:   if (line_start) state_next = TRACK;
                TRACK:   if (any_err) state_next = SEEK;
                default: state_next = SEEK;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEEK;
        else     state <= state_next;
    end

    // Raster position, running CRC and the one-cycle-late frame-end marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            vs_line  <= 1'b0;
            crc      <= 16'hFFFF;
            end_pend <= 1'b0;
        end else begin
            if (line_start) vs_line <= vs_r;
            if (en && (state == ALIGN) && line_start) begin
                h_cnt    <= '0;
                v_cnt    <= '0;
                crc      <= 16'hFFFF;
                end_pend <= 1'b0;
            end else begin
                h_cnt <= cur_h;
                v_cnt <= cur_v;
                if (tracking && v_assert_line)
                    crc <= 16'hFFFF;
                else if (tracking && active)
                    crc <= crc_step(crc, rgb_r);
                end_pend <= tracking && !any_err && last_px;
            end
        end
    end

    // Published results: frame signature, frame counter, lock status and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_crc   <= '0;
            frame_count <= '0;
            err_hsync   <= 1'b0;
            err_vsync   <= 1'b0;
            err_blank   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_hsync  <= (err_hsync & ~clear_err) | det_h;
            err_vsync  <= (err_vsync & ~clear_err) | det_v;
            err_blank  <= (err_blank & ~clear_err) | det_b;
            if (!en || any_err) begin
                locked <= 1'b0;
            end else if (end_pend && (state == TRACK)) begin
                frame_done  <= 1'b1;
                frame_crc   <= crc;
                frame_count <= frame_count + 16'd1;
                locked      <= 1'b1;
            end
        end
    end

endmodule
